// File: rtl/hamming_scrub_pkg.sv
// Shared types and per-block constants for the Hamming scrub controller.
package hamming_scrub_pkg;

  localparam int DATA_BITS_PER_BLK = 4;
  localparam int PAR_BITS_PER_BLK  = 3;

  localparam int DEF_WIDTH       = 64;
  localparam int DEF_BLOCKS      = DEF_WIDTH / DATA_BITS_PER_BLK;
  localparam int DEF_PARITY_BITS = DEF_BLOCKS * PAR_BITS_PER_BLK;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_PAUSE,
    ST_CHECK,
    ST_CORRECT,
    ST_DONE
  } scrub_state_e;

  // Number of Hamming blocks covering a counter of the given width.
  function automatic int blocks_of(input int width);
    return width / DATA_BITS_PER_BLK;
  endfunction

endpackage

// File: rtl/syndrome_block_flags.sv
// Per-block error flags and their popcount, derived from a captured syndrome.
module syndrome_block_flags
  import hamming_scrub_pkg::*;
#(
  parameter int BLOCKS = DEF_BLOCKS,
  parameter int POP_W  = $clog2(BLOCKS + 1)
) (
  input  logic [BLOCKS*PAR_BITS_PER_BLK-1:0] i_syn,
  output logic [BLOCKS-1:0]                  o_flags,
  output logic [POP_W-1:0]                   o_pop
);

  // Any nonzero 3-bit block syndrome counts as one correctable error.
  always_comb begin
    o_flags = '0;
    o_pop   = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      o_flags[b] = |i_syn[b*PAR_BITS_PER_BLK +: PAR_BITS_PER_BLK];
      o_pop      = o_pop + POP_W'(o_flags[b]);
    end
  end

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Scrub controller for the Hamming-protected counter datapath.
// Owns the datapath enable, pauses counting for periodic / on-demand scrubs,
// and keeps saturating error statistics plus a sticky per-block error map.
// Optional feature macro: HAMMING_SCRUB_IRQ_EN (adds IRQ_THRESHOLD, irq_clr, irq).
module hamming_scrub_ctrl
  import hamming_scrub_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int BLOCKS        = blocks_of(WIDTH),
  parameter int PARITY_BITS   = BLOCKS * PAR_BITS_PER_BLK,
  parameter int SCRUB_PERIOD  = 1024,
  parameter int SETTLE_CYCLES = 2,
  parameter int CORR_CYCLES   = 2,
  parameter int CNT_W         = 16
`ifdef HAMMING_SCRUB_IRQ_EN
  ,
  parameter int IRQ_THRESHOLD = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   user_en,
  input  logic                   scrub_req,
  input  logic [PARITY_BITS-1:0] syndrome,
  input  logic                   err_clr,
`ifdef HAMMING_SCRUB_IRQ_EN
  input  logic                   irq_clr,
  output logic                   irq,
`endif
  output logic                   counter_en,
  output logic                   user_stall,
  output logic                   scrub_busy,
  output logic                   scrub_done,
  output logic [CNT_W-1:0]       err_count,
  output logic [BLOCKS-1:0]      err_map
);

  localparam int POP_W  = $clog2(BLOCKS + 1);
  localparam int TMR_W  = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam int PH_MAX = (SETTLE_CYCLES > CORR_CYCLES) ? SETTLE_CYCLES : CORR_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  if ((BLOCKS * DATA_BITS_PER_BLK != WIDTH) || (PARITY_BITS != BLOCKS * PAR_BITS_PER_BLK) ||
      (SETTLE_CYCLES < 2) || (CORR_CYCLES < 1)) begin : g_param_err
    $error("hamming_scrub_ctrl: inconsistent parameters");
  end

  scrub_state_e            r_state;
  scrub_state_e            w_state_nxt;
  logic [TMR_W-1:0]        r_timer;
  logic [PH_W-1:0]         r_phase;
  logic [PARITY_BITS-1:0]  r_syn;
  logic [BLOCKS-1:0]       w_flags;
  logic [POP_W-1:0]        w_pop;
  logic                    w_any_flag;
  logic                    w_period_hit;
  logic                    w_stat_upd;

  // Saturating add of a block popcount onto the error counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [POP_W-1:0] b);
    logic [CNT_W+POP_W:0] sum;
    sum = {{(POP_W+1){1'b0}}, a} + {{(CNT_W+1){1'b0}}, b};
    if (sum > {{(POP_W+1){1'b0}}, {CNT_W{1'b1}}}) return '1;
    return sum[CNT_W-1:0];
  endfunction

  syndrome_block_flags #(
    .BLOCKS (BLOCKS),
    .POP_W  (POP_W)
  ) u_flags (
    .i_syn   (r_syn),
    .o_flags (w_flags),
    .o_pop   (w_pop)
  );

  assign w_any_flag   = |w_flags;
  assign w_period_hit = (SCRUB_PERIOD != 0) && (r_timer == TMR_W'(SCRUB_PERIOD - 1));
  assign w_stat_upd   = (r_state == ST_CHECK) && w_any_flag;

  // Next-state and enable arbitration; every combinational output is forced low in reset.
  always_comb begin
    w_state_nxt = r_state;
    counter_en  = 1'b0;
    scrub_done  = 1'b0;
    case (r_state)
      ST_RUN: begin
        counter_en = user_en;
        if (scrub_req || w_period_hit) w_state_nxt = ST_PAUSE;
      end
      ST_PAUSE:   if (r_phase == PH_W'(SETTLE_CYCLES - 1)) w_state_nxt = ST_CHECK;
      ST_CHECK:   w_state_nxt = w_any_flag ? ST_CORRECT : ST_DONE;
      ST_CORRECT: if (r_phase == PH_W'(CORR_CYCLES - 1)) w_state_nxt = ST_DONE;
      ST_DONE: begin
        scrub_done  = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default:    w_state_nxt = ST_RUN;
    endcase
    scrub_busy = (r_state != ST_RUN);
    user_stall = user_en & scrub_busy;
    if (rst) begin
      counter_en = 1'b0;
      scrub_done = 1'b0;
      scrub_busy = 1'b0;
      user_stall = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Cycle count within PAUSE / CORRECT; restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst || (w_state_nxt != r_state)) r_phase <= '0;
    else                                 r_phase <= r_phase + PH_W'(1);
  end

  // Interval timer: counts RUN cycles, cleared when a scrub completes.
  always_ff @(posedge clk) begin
    if (rst)                    r_timer <= '0;
    else if (r_state == ST_DONE) r_timer <= '0;
    else if (r_state == ST_RUN)  r_timer <= r_timer + TMR_W'(1);
  end

  // ---- syndrome capture after the settle window ----
  // Capture the syndrome at the last PAUSE cycle so CHECK sees a stable value.
  always_ff @(posedge clk) begin
    if ((r_state == ST_PAUSE) && (w_state_nxt == ST_CHECK)) r_syn <= syndrome;
  end

  // ---- statistics update on CORRECT entry ----
  // A clear colliding with an update reloads the statistics from the new flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
      err_map   <= '0;
    end else if (err_clr && w_stat_upd) begin
      err_count <= sat_add('0, w_pop);
      err_map   <= w_flags;
    end else if (err_clr) begin
      err_count <= '0;
      err_map   <= '0;
    end else if (w_stat_upd) begin
      err_count <= sat_add(err_count, w_pop);
      err_map   <= err_map | w_flags;
    end
  end

`ifdef HAMMING_SCRUB_IRQ_EN
  // Sticky threshold interrupt; re-arms the cycle after a clear if still over threshold.
  always_ff @(posedge clk) begin
    if (rst || irq_clr)                          irq <= 1'b0;
    else if (32'(err_count) >= 32'(IRQ_THRESHOLD)) irq <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl: periodic scrubs, on-demand scrubs
// with errors, saturation, clear collision, reset mid-scrub and optional IRQ.
module tb_hamming_scrub_ctrl;

  logic        clk;
  logic        rst;
  logic        user_en;
  logic        scrub_req;
  logic        err_clr;
  logic [47:0] syndrome;
  logic        counter_en, user_stall, scrub_busy, scrub_done;
  logic [3:0]  err_count;
  logic [15:0] err_map;
`ifdef HAMMING_SCRUB_IRQ_EN
  logic        irq_clr;
  logic        irq;
  logic        p_irq;
`endif
  logic        p_counter_en, p_user_stall, p_scrub_busy, p_scrub_done;
  logic [15:0] p_err_count;
  logic [15:0] p_err_map;

  int n_chk  = 0;
  int n_fail = 0;

  hamming_scrub_ctrl #(
    .SCRUB_PERIOD (0),
    .CNT_W        (4)
`ifdef HAMMING_SCRUB_IRQ_EN
    ,
    .IRQ_THRESHOLD(3)
`endif
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .user_en    (user_en),
    .scrub_req  (scrub_req),
    .syndrome   (syndrome),
    .err_clr    (err_clr),
`ifdef HAMMING_SCRUB_IRQ_EN
    .irq_clr    (irq_clr),
    .irq        (irq),
`endif
    .counter_en (counter_en),
    .user_stall (user_stall),
    .scrub_busy (scrub_busy),
    .scrub_done (scrub_done),
    .err_count  (err_count),
    .err_map    (err_map)
  );

  hamming_scrub_ctrl #(
    .SCRUB_PERIOD (16)
  ) u_per (
    .clk        (clk),
    .rst        (rst),
    .user_en    (1'b1),
    .scrub_req  (1'b0),
    .syndrome   (48'h0),
    .err_clr    (1'b0),
`ifdef HAMMING_SCRUB_IRQ_EN
    .irq_clr    (1'b0),
    .irq        (p_irq),
`endif
    .counter_en (p_counter_en),
    .user_stall (p_user_stall),
    .scrub_busy (p_scrub_busy),
    .scrub_done (p_scrub_done),
    .err_count  (p_err_count),
    .err_map    (p_err_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's drive point and drop single-cycle pulses.
  task automatic next_cycle();
    @(negedge clk);
    scrub_req = 1'b0;
    err_clr   = 1'b0;
`ifdef HAMMING_SCRUB_IRQ_EN
    irq_clr   = 1'b0;
`endif
  endtask

  // One on-demand scrub from RUN, checking the enable/busy/done profile each cycle.
  task automatic do_scrub(input logic [47:0] syn, input bit has_err, input bit clr_in_check);
    int len;
    len = has_err ? 6 : 4;
    next_cycle();
    syndrome  = syn;
    scrub_req = 1'b1;
    #1;
    chk("req_en", counter_en, 1);
    chk("req_busy", scrub_busy, 0);
    for (int c = 1; c <= len + 1; c++) begin
      next_cycle();
      if (clr_in_check && c == 3) err_clr = 1'b1;
      #1;
      chk("scr_en",    counter_en, (c > len) ? 1 : 0);
      chk("scr_busy",  scrub_busy, (c <= len) ? 1 : 0);
      chk("scr_stall", user_stall, (c <= len) ? 1 : 0);
      chk("scr_done",  scrub_done, (c == len) ? 1 : 0);
    end
    syndrome = '0;
  endtask

  initial begin
    rst       = 1'b1;
    user_en   = 1'b1;
    scrub_req = 1'b0;
    err_clr   = 1'b0;
    syndrome  = '0;
`ifdef HAMMING_SCRUB_IRQ_EN
    irq_clr   = 1'b0;
`endif

    // Reset state: outputs low even with user_en high.
    next_cycle();
    #1;
    chk("rst_en",    counter_en, 0);
    chk("rst_busy",  scrub_busy, 0);
    chk("rst_stall", user_stall, 0);
    chk("rst_done",  scrub_done, 0);
    chk("rst_cnt",   err_count, 0);
    chk("rst_map",   err_map, 0);
    chk("rst_p_en",  p_counter_en, 0);

    // Periodic scrubs: 16 RUN cycles then 4 low cycles (PAUSE x2, CHECK, DONE).
    next_cycle();
    rst = 1'b0;
    #1;
    chk("run_en", counter_en, 1);
    for (int k = 0; k < 60; k++) begin
      if (k > 0) begin
        next_cycle();
        #1;
      end
      chk("per_en",    p_counter_en, ((k % 20) < 16) ? 1 : 0);
      chk("per_busy",  p_scrub_busy, ((k % 20) < 16) ? 0 : 1);
      chk("per_stall", p_user_stall, p_scrub_busy);
      chk("per_done",  p_scrub_done, ((k % 20) == 19) ? 1 : 0);
    end
    chk("per_cnt", p_err_count, 0);
    chk("per_map", p_err_map, 0);

    // On-demand with errors in blocks 0 and 5.
    do_scrub(48'h8003, 1'b1, 1'b0);
    chk("err_cnt", err_count, 2);
    chk("err_map", err_map, 16'h0021);

    // Clean scrub leaves statistics untouched.
    do_scrub(48'h0, 1'b0, 1'b0);
    chk("clean_cnt", err_count, 2);
    chk("clean_map", err_map, 16'h0021);

    // Saturation at 15 with all blocks flagged.
    do_scrub(48'hFFFF_FFFF_FFFF, 1'b1, 1'b0);
    chk("sat1_cnt", err_count, 15);
    chk("sat1_map", err_map, 16'hFFFF);
    do_scrub(48'hFFFF_FFFF_FFFF, 1'b1, 1'b0);
    chk("sat2_cnt", err_count, 15);

    // Clear colliding with CORRECT entry, block 2 flagged.
    do_scrub(48'h100, 1'b1, 1'b1);
    chk("coll_cnt", err_count, 1);
    chk("coll_map", err_map, 16'h0004);

    // Plain clear.
    next_cycle();
    err_clr = 1'b1;
    #1;
    next_cycle();
    #1;
    chk("clr_cnt", err_count, 0);
    chk("clr_map", err_map, 0);

    // Reset during CORRECT.
    next_cycle();
    syndrome  = 48'h8003;
    scrub_req = 1'b1;
    #1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      #1;
    end
    next_cycle();
    rst = 1'b1;
    #1;
    chk("mid_cnt",   err_count, 2);
    chk("mid_map",   err_map, 16'h0021);
    chk("mid_en",    counter_en, 0);
    chk("mid_busy",  scrub_busy, 0);
    chk("mid_stall", user_stall, 0);
    next_cycle();
    rst      = 1'b0;
    syndrome = '0;
    #1;
    chk("post_en",   counter_en, 1);
    chk("post_busy", scrub_busy, 0);
    chk("post_done", scrub_done, 0);
    chk("post_cnt",  err_count, 0);
    chk("post_map",  err_map, 0);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      user_en = (k % 2 == 0);
      #1;
      chk("follow_en",   counter_en, user_en);
      chk("follow_done", scrub_done, 0);
      chk("follow_busy", scrub_busy, 0);
    end
    user_en = 1'b1;

`ifdef HAMMING_SCRUB_IRQ_EN
    chk("irq_idle", irq, 0);
    do_scrub(48'h49, 1'b1, 1'b0);
    chk("irq_cnt", err_count, 3);
    chk("irq_set", irq, 1);
    next_cycle();
    irq_clr = 1'b1;
    #1;
    chk("irq_hold", irq, 1);
    next_cycle();
    #1;
    chk("irq_cleared", irq, 0);
    next_cycle();
    #1;
    chk("irq_reassert", irq, 1);
    next_cycle();
    err_clr = 1'b1;
    #1;
    next_cycle();
    #1;
    chk("irq_cnt0", err_count, 0);
    chk("irq_sticky", irq, 1);
    next_cycle();
    irq_clr = 1'b1;
    #1;
    next_cycle();
    #1;
    chk("irq_off", irq, 0);
    next_cycle();
    #1;
    chk("irq_stay_off", irq, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
